relm_div_arb: RTL

//  Shares one iterative divider between NREQ requesters (custom-op issue slots) and sequences it.

---
 rtl/relm_div_arb_pkg.sv | 25 ++
 rtl/relm_lower.sv | 20 ++
 rtl/relm_div_arb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/relm_div_arb_pkg.sv
// Shared definitions for the arbitrated iterative divider: FSM states,
// divide-by-zero quotient and a one-hot to index helper.
package relm_div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Quotient reported on divide-by-zero (sliced to the operand width).
  localparam logic [63:0] DZ_QUOT = '1;

  function automatic logic [6:0] onehot_index(input logic [63:0] oh);
    logic [6:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | 7'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/relm_lower.sv
// Smears the highest set bit of x down to bit 0: y[i] = |x[W-1:i].
module relm_lower #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic run;

  always_comb begin
    y   = '0;
    run = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      run          = run | x[W-1-i];
      y[W-1-i]     = run;
    end
  end

endmodule

// File: rtl/relm_div_arb.sv
// Round-robin shared radix-2 divider: normalise, iterate msb(N)-msb(D)+1 steps,
// sign-fix, then hold a tagged result until accepted.
module relm_div_arb
  import relm_div_arb_pkg::*;
#(
  parameter int unsigned WD   = 32,
  parameter int unsigned NREQ = 2,
  parameter int unsigned WID  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_signed,
  input  logic [NREQ*WD-1:0] req_n,
  input  logic [NREQ*WD-1:0] req_d,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WID-1:0]     rsp_id,
  output logic [WD-1:0]      rsp_q,
  output logic [WD-1:0]      rsp_r,
  output logic               rsp_dz,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WD + 1);

  state_t         state;
  logic [WID-1:0] rr;
  logic [WID-1:0] id;
  logic [WD-1:0]  n_raw, n_mag, d_mag, rem, div, quo;
  logic           neg_n, neg_d, dz;
  logic [CW-1:0]  cnt;

  // MSB of found flag, low bits the granted index.
  function automatic logic [WID:0] rr_pick(input logic [NREQ-1:0] v, input logic [WID-1:0] p);
    logic [WID:0] res;
    logic         found;
    int unsigned  idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(p) + k) % NREQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        res   = {1'b1, WID'(idx)};
      end
    end
    return res;
  endfunction

  logic [WID:0]   pick;
  logic [WID-1:0] gid;
  logic           accept;
  logic [WD-1:0]  gn, gd;
  logic           gs;

  assign pick   = rr_pick(req_valid, rr);
  assign gid    = pick[WID-1:0];
  assign accept = (state == IDLE) && !rst && pick[WID];
  assign gn     = req_n[32'(gid)*WD +: WD];
  assign gd     = req_d[32'(gid)*WD +: WD];
  assign gs     = req_signed[gid];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gid] = 1'b1;
  end

  logic [WD-1:0] low_n, low_d;
  logic [6:0]    msb_n, msb_d;
  logic [7:0]    nbits;

  relm_lower #(.W(WD)) u_low_n (.x(n_mag), .y(low_n));
  relm_lower #(.W(WD)) u_low_d (.x(d_mag), .y(low_d));

  assign msb_n = onehot_index(64'(low_n ^ (low_n >> 1)));
  assign msb_d = onehot_index(64'(low_d ^ (low_d >> 1)));
  assign nbits = (n_mag >= d_mag) ? ({1'b0, msb_n} - {1'b0, msb_d} + 8'd1) : 8'd0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      id        <= '0;
      n_raw     <= '0;
      n_mag     <= '0;
      d_mag     <= '0;
      rem       <= '0;
      div       <= '0;
      quo       <= '0;
      neg_n     <= 1'b0;
      neg_d     <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_raw <= gn;
            n_mag <= (gs && gn[WD-1]) ? -gn : gn;
            d_mag <= (gs && gd[WD-1]) ? -gd : gd;
            neg_n <= gs && gn[WD-1];
            neg_d <= gs && gd[WD-1];
            id    <= gid;
            rr    <= WID'((32'(gid) + 1) % NREQ);
            state <= NORM;
          end
        end
        NORM: begin
          quo <= '0;
          dz  <= 1'b0;
          if (d_mag == '0) begin
            quo   <= DZ_QUOT[WD-1:0];
            rem   <= n_raw;
            dz    <= 1'b1;
            state <= FIX;
          end else if (nbits == 8'd0) begin
            rem   <= n_mag;
            state <= FIX;
          end else begin
            rem   <= n_mag;
            div   <= d_mag << (nbits - 8'd1);
            cnt   <= nbits[CW-1:0];
            state <= ITER;
          end
        end
        ITER: begin
          if (rem >= div) begin
            rem <= rem - div;
            quo <= {quo[WD-2:0], 1'b1};
          end else begin
            quo <= {quo[WD-2:0], 1'b0};
          end
          div <= div >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero results bypass the sign fix.
          rsp_id    <= id;
          rsp_dz    <= dz;
          rsp_q     <= (!dz && (neg_n ^ neg_d)) ? -quo : quo;
          rsp_r     <= (!dz && neg_n) ? -rem : rem;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
